seg7_reader: RTL and testbench

- Capture-side counterpart of the board's 7-segment driver path: samples the active-low segment and digit-select lines of a multiplexed common-anode display and recovers hex digit values.
- Used to read a second board's display, or looped back on our own pins for self-test.
- Output is per-digit nibble, decimal point, valid, blank and error status, plus a one-cycle update strobe.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 20 ++
 rtl/seg7_reader.sv | 198 +++++++++++++++++++
 tb/tb_seg7_reader.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order and the hex glyph table used by both
// the driver (encode) and the reader (decode) so the two sides can never disagree.
package seg7_pkg;

  typedef enum int unsigned {
    SEG_A,
    SEG_B,
    SEG_C,
    SEG_D,
    SEG_E,
    SEG_F,
    SEG_G,
    SEG_DP
  } seg_bit_e;

  // Entry n is the active-high a..g pattern for hex digit n.
  localparam logic [15:0][6:0] HEX_SEGS = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       legal;
    logic       blank;
  } seg7_dec_t;

  function automatic logic [6:0] hex_to_segs(input logic [3:0] nibble);
    return HEX_SEGS[nibble];
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational reverse lookup of an a..g pattern into {nibble, legal, blank}.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segs_i,
  output seg7_dec_t  dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.blank = (segs_i == 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (segs_i == hex_to_segs(4'(i))) begin
        dec_o.nibble = 4'(i);
        dec_o.legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// Samples a multiplexed common-anode 7-segment display and recovers per-digit hex values,
// decimal points and valid/blank status, with a one-cycle change strobe.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 65536
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7:0]            i_segs_n,
  input  logic [DIGITS-1:0]     i_dig_n,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic [DIGITS-1:0]     o_dp,
  output logic [DIGITS-1:0]     o_valid,
  output logic [DIGITS-1:0]     o_blank,
  output logic                  o_update,
  output logic [2:0]            o_upd_idx,
  output logic                  o_err
);

  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned AW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntMax  = CW'(STABLE_CYCLES - 1);
  localparam logic [AW-1:0] AgeMax  = AW'(TIMEOUT);
  localparam logic [AW-1:0] AgeLast = AW'(TIMEOUT - 1);

  logic [7:0]        segs_s1_q, segs_s1_d, segs_s2_q, segs_s2_d, segs_prev_q, segs_prev_d;
  logic [DIGITS-1:0] dig_s1_q, dig_s1_d, dig_s2_q, dig_s2_d, dig_prev_q, dig_prev_d;
  logic [2:0]        fill_q, fill_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cap_q, cap_d;
  logic [7:0]        cap_segs_q, cap_segs_d;
  logic [2:0]        cap_idx_q, cap_idx_d;

  logic [DIGITS-1:0][3:0]    digits_q, digits_d;
  logic [DIGITS-1:0]         dp_q, dp_d, valid_q, valid_d, blank_q, blank_d;
  logic [DIGITS-1:0]         pend_q, pend_d;
  logic [DIGITS-1:0][AW-1:0] age_q, age_d;
  logic                      update_q, update_d, err_q, err_d;
  logic [2:0]                upd_idx_q, upd_idx_d;

  logic [7:0]        segs;
  logic [DIGITS-1:0] dig;
  logic              eligible, fire, found;
  logic [2:0]        idx;
  logic [DIGITS-1:0] expire;
  seg7_dec_t         dec;

  assign segs = ~segs_s2_q;
  assign dig  = ~dig_s2_q;

  // Input conditioning and sample qualification.
  always_comb begin
    segs_s1_d   = i_segs_n;
    segs_s2_d   = segs_s1_q;
    segs_prev_d = segs_s2_q;
    dig_s1_d    = i_dig_n;
    dig_s2_d    = dig_s1_q;
    dig_prev_d  = dig_s2_q;
    // fill_q[2] marks that the compare register holds a real post-reset sample.
    fill_d      = {fill_q[1:0], 1'b1};

    idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (dig[k]) idx = 3'(k);
    end

    eligible = fill_q[2] && $onehot(dig) &&
               (segs_s2_q == segs_prev_q) && (dig_s2_q == dig_prev_q);

    cnt_d = cnt_q;
    if (!eligible) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    fire = eligible && (cnt_q != CntMax) && (cnt_d == CntMax);

    cap_d      = fire;
    cap_segs_d = fire ? segs : cap_segs_q;
    cap_idx_d  = fire ? idx : cap_idx_q;
  end

  seg7_decode u_decode (
    .segs_i (cap_segs_q[6:0]),
    .dec_o  (dec)
  );

  // Age counters; a timed-out digit is only interesting if it still shows valid or blank.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      expire[k] = (pend_q[k] || (age_q[k] == AgeLast)) && (valid_q[k] || blank_q[k]);
      if (cap_q && (cap_idx_q == 3'(k))) begin
        age_d[k] = '0;
      end else if (age_q[k] != AgeMax) begin
        age_d[k] = age_q[k] + 1'b1;
      end else begin
        age_d[k] = age_q[k];
      end
    end
  end

  // Store stage: a capture owns the update strobe; timeouts wait in pend_q meanwhile.
  always_comb begin
    digits_d  = digits_q;
    dp_d      = dp_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    pend_d    = expire;
    update_d  = 1'b0;
    upd_idx_d = upd_idx_q;
    err_d     = 1'b0;
    found     = 1'b0;
    if (cap_q) begin
      err_d = !dec.legal && !dec.blank;
      for (int k = 0; k < DIGITS; k++) begin
        if (cap_idx_q == 3'(k)) begin
          if (dec.legal) digits_d[k] = dec.nibble;
          dp_d[k]    = cap_segs_q[SEG_DP];
          valid_d[k] = dec.legal;
          blank_d[k] = dec.blank;
          pend_d[k]  = 1'b0;
          update_d   = (digits_d[k] != digits_q[k]) || (dp_d[k] != dp_q[k]) ||
                       (valid_d[k] != valid_q[k]) || (blank_d[k] != blank_q[k]);
        end
      end
      if (update_d) upd_idx_d = cap_idx_q;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        if (expire[k] && !found) begin
          found      = 1'b1;
          valid_d[k] = 1'b0;
          blank_d[k] = 1'b0;
          pend_d[k]  = 1'b0;
          update_d   = 1'b1;
          upd_idx_d  = 3'(k);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      segs_s1_q   <= '0;
      segs_s2_q   <= '0;
      segs_prev_q <= '0;
      dig_s1_q    <= '0;
      dig_s2_q    <= '0;
      dig_prev_q  <= '0;
      fill_q      <= '0;
      cnt_q       <= '0;
      cap_q       <= 1'b0;
      cap_segs_q  <= '0;
      cap_idx_q   <= '0;
      digits_q    <= '0;
      dp_q        <= '0;
      valid_q     <= '0;
      blank_q     <= '0;
      pend_q      <= '0;
      age_q       <= '0;
      update_q    <= 1'b0;
      upd_idx_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      segs_s1_q   <= segs_s1_d;
      segs_s2_q   <= segs_s2_d;
      segs_prev_q <= segs_prev_d;
      dig_s1_q    <= dig_s1_d;
      dig_s2_q    <= dig_s2_d;
      dig_prev_q  <= dig_prev_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      cap_segs_q  <= cap_segs_d;
      cap_idx_q   <= cap_idx_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      valid_q     <= valid_d;
      blank_q     <= blank_d;
      pend_q      <= pend_d;
      age_q       <= age_d;
      update_q    <= update_d;
      upd_idx_q   <= upd_idx_d;
      err_q       <= err_d;
    end
  end

  assign o_digits  = digits_q;
  assign o_dp      = dp_q;
  assign o_valid   = valid_q;
  assign o_blank   = blank_q;
  assign o_update  = update_q;
  assign o_upd_idx = upd_idx_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios plus randomized holds checked against a
// digit-level model of the display reader.
module tb_seg7_reader;

  localparam int unsigned S = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  segs_n;
  logic [3:0]  dig_n;

  logic [15:0] digits, digits_to;
  logic [3:0]  dp, valid, blank, dp_to, valid_to, blank_to;
  logic        update, err, update_to, err_to;
  logic [2:0]  upd_idx, upd_idx_to;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  logic [6:0] pat_tab [16];
  logic [3:0] m_dig [4];
  logic [3:0] m_dp, m_valid, m_blank;

  seg7_reader #(.DIGITS(4), .STABLE_CYCLES(S), .TIMEOUT(65536)) dut (
    .i_clk(clk), .i_reset(rst), .i_segs_n(segs_n), .i_dig_n(dig_n),
    .o_digits(digits), .o_dp(dp), .o_valid(valid), .o_blank(blank),
    .o_update(update), .o_upd_idx(upd_idx), .o_err(err)
  );

  seg7_reader #(.DIGITS(4), .STABLE_CYCLES(S), .TIMEOUT(64)) dut_to (
    .i_clk(clk), .i_reset(rst), .i_segs_n(segs_n), .i_dig_n(dig_n),
    .o_digits(digits_to), .o_dp(dp_to), .o_valid(valid_to), .o_blank(blank_to),
    .o_update(update_to), .o_upd_idx(upd_idx_to), .o_err(err_to)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update) upd_cnt <= upd_cnt + 1;
    if (err)    err_cnt <= err_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] dn, input logic [7:0] sn);
    dig_n  = dn;
    segs_n = sn;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'hF, 8'hFF);
    tick(3);
    rst = 1'b0;
    tick(4);
  endtask

  // Digit-level model of one capture: returns whether any field changed and if it was illegal.
  task automatic model_capture(input int k, input logic [7:0] s, output bit chg, output bit bad);
    logic [3:0] nib;
    bit legal;
    bit blk;
    nib   = m_dig[k];
    legal = 0;
    blk   = (s[6:0] == 7'h00);
    for (int i = 0; i < 16; i++) begin
      if (pat_tab[i] == s[6:0]) begin
        legal = 1;
        nib   = 4'(i);
      end
    end
    chg = (nib != m_dig[k]) || (s[7] != m_dp[k]) || (legal != m_valid[k]) || (blk != m_blank[k]);
    bad = !legal && !blk;
    m_dig[k]   = nib;
    m_dp[k]    = s[7];
    m_valid[k] = legal;
    m_blank[k] = blk;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(4'hF, 8'hFF);
    tick(3);
    n_tests++; if (digits !== 16'h0) begin n_fail++; $display("FAIL reset_digits: got %h expected 0000", digits); end
    n_tests++; if (dp !== 4'h0) begin n_fail++; $display("FAIL reset_dp: got %b expected 0000", dp); end
    n_tests++; if (valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", valid); end
    n_tests++; if (blank !== 4'h0) begin n_fail++; $display("FAIL reset_blank: got %b expected 0000", blank); end
    n_tests++; if ({update, upd_idx, err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_strobes: got upd=%b idx=%0d err=%b expected 0", update, upd_idx, err);
    end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_single();
    int u0, e0;
    u0 = upd_cnt; e0 = err_cnt;
    drive(4'b1110, ~8'h4F);
    tick(S + 2);
    n_tests++; if (valid !== 4'b0000) begin n_fail++; $display("FAIL single_early: valid got %b expected 0000", valid); end
    tick(1);
    n_tests++; if (digits[3:0] !== 4'h3) begin n_fail++; $display("FAIL single_digit: got %h expected 3", digits[3:0]); end
    n_tests++; if (valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b expected 0001", valid); end
    n_tests++; if (update !== 1'b1 || upd_idx !== 3'd0) begin
      n_fail++; $display("FAIL single_update: got upd=%b idx=%0d expected upd=1 idx=0", update, upd_idx);
    end
    tick(20 - (S + 3));
    drive(4'hF, 8'hFF);
    tick(4);
    n_tests++; if (upd_cnt - u0 != 1) begin n_fail++; $display("FAIL single_upd_count: got %0d expected 1", upd_cnt - u0); end
    n_tests++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL single_err: got %0d expected 0", err_cnt - e0); end
  endtask

  task automatic scan_once();
    logic [6:0] pats [4];
    pats[0] = 7'h06; pats[1] = 7'h5B; pats[2] = 7'h77; pats[3] = 7'h71;
    for (int k = 0; k < 4; k++) begin
      drive(~(4'b0001 << k), ~{(k == 2), pats[k]});
      tick(40);
    end
    drive(4'hF, 8'hFF);
    tick(4);
  endtask

  task automatic test_scan();
    int u0;
    u0 = upd_cnt;
    scan_once();
    n_tests++; if (digits !== 16'hFA21) begin n_fail++; $display("FAIL scan_digits: got %h expected FA21", digits); end
    n_tests++; if (dp !== 4'b0100) begin n_fail++; $display("FAIL scan_dp: got %b expected 0100", dp); end
    n_tests++; if (valid !== 4'b1111) begin n_fail++; $display("FAIL scan_valid: got %b expected 1111", valid); end
    n_tests++; if (upd_cnt - u0 != 4) begin n_fail++; $display("FAIL scan_updates: got %0d expected 4", upd_cnt - u0); end
    u0 = upd_cnt;
    scan_once();
    n_tests++; if (upd_cnt - u0 != 0) begin n_fail++; $display("FAIL rescan_updates: got %0d expected 0", upd_cnt - u0); end
  endtask

  task automatic test_glitch();
    int u0;
    u0 = upd_cnt;
    for (int i = 0; i < 6; i++) begin
      drive(4'b1110, (i % 2 == 0) ? ~8'h06 : ~8'h5B);
      tick(8);
    end
    drive(4'hF, 8'hFF);
    tick(4);
    n_tests++; if (upd_cnt - u0 != 0) begin n_fail++; $display("FAIL glitch_updates: got %0d expected 0", upd_cnt - u0); end
    n_tests++; if (digits !== 16'hFA21 || valid !== 4'b1111) begin
      n_fail++; $display("FAIL glitch_state: got %h/%b expected FA21/1111", digits, valid);
    end
  endtask

  task automatic test_illegal();
    int u0, e0;
    u0 = upd_cnt; e0 = err_cnt;
    drive(4'b1101, ~8'h49);
    tick(30);
    n_tests++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL illegal_err: got %0d expected 1", err_cnt - e0); end
    n_tests++; if (valid[1] !== 1'b0 || blank[1] !== 1'b0) begin
      n_fail++; $display("FAIL illegal_flags: got valid=%b blank=%b expected 0/0", valid[1], blank[1]);
    end
    n_tests++; if (digits[7:4] !== 4'h2) begin n_fail++; $display("FAIL illegal_retain: got %h expected 2", digits[7:4]); end
    u0 = upd_cnt; e0 = err_cnt;
    drive(4'b1101, 8'hFF);
    tick(30);
    n_tests++; if (blank[1] !== 1'b1 || valid[1] !== 1'b0) begin
      n_fail++; $display("FAIL blank_flags: got blank=%b valid=%b expected 1/0", blank[1], valid[1]);
    end
    n_tests++; if (upd_cnt - u0 != 1) begin n_fail++; $display("FAIL blank_updates: got %0d expected 1", upd_cnt - u0); end
    n_tests++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL blank_err: got %0d expected 0", err_cnt - e0); end
    drive(4'hF, 8'hFF);
    tick(4);
  endtask

  task automatic test_timeout();
    bit seen;
    seen = 0;
    drive(4'hF, 8'hFF);
    tick(100);
    drive(4'b0111, ~8'h07);
    for (int i = 0; i < 40 && !seen; i++) begin
      tick(1);
      if (valid_to[3] === 1'b1) seen = 1;
    end
    drive(4'hF, 8'hFF);
    n_tests++;
    if (!seen) begin
      n_fail++; $display("FAIL timeout_capture: valid[3] got 0 expected 1 within 40 cycles");
    end else begin
      tick(63);
      n_tests++; if (valid_to[3] !== 1'b1) begin n_fail++; $display("FAIL timeout_early: valid[3] got 0 expected 1"); end
      tick(1);
      n_tests++; if (valid_to[3] !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: valid[3] got 1 expected 0"); end
      n_tests++; if (update_to !== 1'b1 || upd_idx_to !== 3'd3) begin
        n_fail++; $display("FAIL timeout_update: got upd=%b idx=%0d expected 1/3", update_to, upd_idx_to);
      end
      n_tests++; if (digits_to[15:12] !== 4'h7) begin n_fail++; $display("FAIL timeout_retain: got %h expected 7", digits_to[15:12]); end
    end
  endtask

  task automatic test_reset_abort();
    int u0;
    drive(4'b1110, ~8'h7F);
    tick(S + 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_tests++; if (digits !== 16'h0 || valid !== 4'h0 || update !== 1'b0) begin
      n_fail++; $display("FAIL abort_reset: got %h/%b/%b expected 0000/0000/0", digits, valid, update);
    end
    u0 = upd_cnt;
    tick(S + 2);
    n_tests++; if (valid !== 4'h0 || upd_cnt - u0 != 0) begin
      n_fail++; $display("FAIL abort_early: got valid=%b updates=%0d expected 0000/0", valid, upd_cnt - u0);
    end
    tick(1);
    n_tests++; if (valid !== 4'b0001 || digits[3:0] !== 4'h8) begin
      n_fail++; $display("FAIL abort_recapture: got valid=%b digit=%h expected 0001/8", valid, digits[3:0]);
    end
    drive(4'hF, 8'hFF);
    tick(4);
  endtask

  task automatic test_random();
    int u0, e0, kind, k, len;
    logic [3:0] dn;
    logic [6:0] pat;
    logic       dpb;
    bit chg, bad;
    do_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
    m_dp = '0; m_valid = '0; m_blank = '0;
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      k    = $urandom_range(0, 3);
      dn   = ~(4'b0001 << k);
      if (kind == 0) begin
        dn = ($urandom_range(0, 1) == 1) ? 4'b0000 : ~((4'b0001 << k) | (4'b0001 << ((k + 1) % 4)));
      end
      case ($urandom_range(0, 7))
        6:       pat = 7'h00;
        7:       pat = 7'($urandom);
        default: pat = pat_tab[$urandom_range(0, 15)];
      endcase
      dpb = 1'($urandom);
      len = ($urandom_range(0, 1) == 1) ? $urandom_range(3, S - 1) : $urandom_range(S, S + 10);
      u0 = upd_cnt; e0 = err_cnt;
      drive(dn, ~{dpb, pat});
      tick(len);
      drive(4'hF, 8'hFF);
      tick(4);
      chg = 0; bad = 0;
      if (kind != 0 && len >= S) model_capture(k, {dpb, pat}, chg, bad);
      n_tests++; if (digits !== {m_dig[3], m_dig[2], m_dig[1], m_dig[0]}) begin
        n_fail++; $display("FAIL rand%0d_digits: got %h expected %h", r, digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
      end
      n_tests++; if ({dp, valid, blank} !== {m_dp, m_valid, m_blank}) begin
        n_fail++; $display("FAIL rand%0d_flags: got dp/valid/blank %b/%b/%b expected %b/%b/%b",
                           r, dp, valid, blank, m_dp, m_valid, m_blank);
      end
      n_tests++; if (upd_cnt - u0 != int'(chg)) begin
        n_fail++; $display("FAIL rand%0d_updates: got %0d expected %0d", r, upd_cnt - u0, int'(chg));
      end
      n_tests++; if (err_cnt - e0 != int'(bad)) begin
        n_fail++; $display("FAIL rand%0d_err: got %0d expected %0d", r, err_cnt - e0, int'(bad));
      end
    end
  endtask

  initial begin
    pat_tab[0]  = 7'h3F; pat_tab[1]  = 7'h06; pat_tab[2]  = 7'h5B; pat_tab[3]  = 7'h4F;
    pat_tab[4]  = 7'h66; pat_tab[5]  = 7'h6D; pat_tab[6]  = 7'h7D; pat_tab[7]  = 7'h07;
    pat_tab[8]  = 7'h7F; pat_tab[9]  = 7'h6F; pat_tab[10] = 7'h77; pat_tab[11] = 7'h7C;
    pat_tab[12] = 7'h39; pat_tab[13] = 7'h5E; pat_tab[14] = 7'h79; pat_tab[15] = 7'h71;
    rst = 1'b1;
    drive(4'hF, 8'hFF);
    test_reset();
    test_single();
    test_scan();
    test_glitch();
    test_illegal();
    test_timeout();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
